// File: rtl/i2s_slave_tx_if.sv
// Push-side bus of the I2S slave transmitter: frame handshake, stereo sample pair and fill level.
interface i2s_slave_tx_if #(
  parameter int unsigned DW         = 24,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_left;
  logic [DW-1:0] s_right;
  logic [LW-1:0] level;

  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready,
    input  level
  );

  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready,
    output level
  );
endinterface

// File: rtl/i2s_slave_tx.sv
// I2S (Philips) slave transmitter: frame FIFO feeding a serializer that follows an external
// sck/ws master, MSB first with one-bit delay after each ws transition.
module i2s_slave_tx #(
  parameter int unsigned DW         = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mono,
  input  logic         clr_udf,
  input  logic         sck,
  input  logic         ws,
  output logic         sdo,
  output logic         underflow,
  i2s_slave_tx_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StLeft, StRight} state_e;

  logic sck_m_q, sck_s_q, sck_d_q;
  logic ws_m_q, ws_s_q, ws_r_q;
  logic pend_q, pend_ch_q;
  logic rise, fall;

  assign rise = sck_s_q & ~sck_d_q;
  assign fall = ~sck_s_q & sck_d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_m_q   <= 1'b0;
      sck_s_q   <= 1'b0;
      sck_d_q   <= 1'b0;
      ws_m_q    <= 1'b0;
      ws_s_q    <= 1'b0;
      ws_r_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_ch_q <= 1'b0;
    end else begin
      sck_m_q <= sck;
      sck_s_q <= sck_m_q;
      sck_d_q <= sck_s_q;
      ws_m_q  <= ws;
      ws_s_q  <= ws_m_q;
      // A ws change seen on a rise marks the next fall as the start of channel ws_s.
      if (rise) begin
        ws_r_q <= ws_s_q;
        if (ws_s_q != ws_r_q) begin
          pend_q    <= 1'b1;
          pend_ch_q <= ws_s_q;
        end
      end else if (fall) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Frame FIFO
  logic [2*DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic            push, pop;
  logic [DW-1:0]   head_l, head_r;

  assign bus.s_ready = (level_q != LW'(FIFO_DEPTH));
  assign bus.level   = level_q;
  assign push        = bus.s_valid & bus.s_ready;
  assign head_l      = mem_q[rptr_q][2*DW-1:DW];
  assign head_r      = mem_q[rptr_q][DW-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {bus.s_left, bus.s_right};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Serializer
  state_e        state_q, state_d;
  logic          sdo_q, sdo_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [DW-1:0] rsave_q, rsave_d;
  logic          udf_q, udf_set;
  logic          start_l, start_r;

  assign start_l = fall & pend_q & ~pend_ch_q;
  assign start_r = fall & pend_q & pend_ch_q;

  always_comb begin
    state_d = state_q;
    sdo_d   = sdo_q;
    sh_d    = sh_q;
    rsave_d = rsave_q;
    pop     = 1'b0;
    udf_set = 1'b0;
    if (!en) begin
      state_d = StIdle;
      sdo_d   = 1'b0;
    end else if (start_l) begin
      state_d = StLeft;
      if (level_q != '0) begin
        pop     = 1'b1;
        sdo_d   = head_l[DW-1];
        sh_d    = {head_l[DW-2:0], 1'b0};
        rsave_d = mono ? head_l : head_r;
      end else begin
        udf_set = 1'b1;
        sdo_d   = 1'b0;
        sh_d    = '0;
        rsave_d = '0;
      end
    end else if (start_r && (state_q != StIdle)) begin
      state_d = StRight;
      sdo_d   = rsave_q[DW-1];
      sh_d    = {rsave_q[DW-2:0], 1'b0};
    end else if (fall) begin
      // Zeros shift in behind the sample, giving pad bits once DW bits are out.
      if (state_q == StIdle) begin
        sdo_d = 1'b0;
      end else begin
        sdo_d = sh_q[DW-1];
        sh_d  = {sh_q[DW-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sdo_q   <= 1'b0;
      sh_q    <= '0;
      rsave_q <= '0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sdo_q   <= sdo_d;
      sh_q    <= sh_d;
      rsave_q <= rsave_d;
      if (udf_set)      udf_q <= 1'b1;
      else if (clr_udf) udf_q <= 1'b0;
    end
  end

  assign sdo       = sdo_q;
  assign underflow = udf_q;
endmodule

// File: doc/i2s_slave_tx.md
Name: i2s_slave_tx

Overview:
Synthesizable I2S slave transmitter. It is the parametrised successor of the fixed-pattern microphone model.
- Serializes stereo (or mono) samples onto sdo, framed by externally mastered sck/ws.
- Samples come from a frame FIFO with valid/ready push.
- Sits between a sample producer (DMA/bus wrapper) and an off-chip or on-chip I2S receiver. Also serves as the bench source for receiver verification.

Parameters:
DW, 24, sample width in bits (8..32)
FIFO_DEPTH, 4, frames buffered; power of two, >= 2

Ports:
clk  input  1  system clock; must be >= 8x sck frequency
rst_n  input  1  synchronous active-low reset
en  input  1  transmit enable
mono  input  1  1: s_left sent in both slots; s_right ignored
clr_udf  input  1  clears underflow (one-cycle pulse)
sck  input  1  I2S bit clock from master, asynchronous to clk
ws  input  1  I2S word select from master (0 = left, 1 = right), asynchronous
sdo  output  1  serial data, MSB first, Philips I2S (one-bit delay)
s_valid  input  1  push request
s_ready  output  1  push accept = (level != FIFO_DEPTH)
s_left  input  DW  left sample of pushed frame
s_right  input  DW  right sample of pushed frame
level  output  $clog2(FIFO_DEPTH)+1  frames in FIFO
underflow  output  1  sticky: a frame started with FIFO empty

Behaviour:
Reset (rst_n=0 at a clk edge), taking effect the same edge:
- sdo=0, level=0, underflow=0, s_ready=1 (once rst_n=1).
- Synchronizers cleared, channel state = IDLE.

Synchronization:
- sck and ws each pass through two flops (sck_s, ws_s), then a delay flop.
- rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
- sdo is registered and updates in the clk cycle following a detected fall: at most 3 clk edges after the physical sck fall.

WS capture:
- On each rise: ws_r <= ws_s.
- If ws_s != ws_r, a boundary is pending for channel ws_s.

States: IDLE, LEFT, RIGHT.
- IDLE: sdo=0. Leaves only on a pending left boundary (ws 1->0) with en=1. A partial first frame after reset/enable is never sent.
- On the first fall after a pending left boundary:
  - Pop FIFO head if level>0; latch left/right (right=left when mono is sampled 1 at pop).
  - If empty: latch zeros, set underflow.
  - Drive MSB; bit counter cnt=1; state LEFT.
- On the first fall after a pending right boundary (state LEFT): drive latched right MSB, cnt=1, state RIGHT.
- Other falls: drive sample[DW-1-cnt] while cnt<DW, else 0 (pad). cnt saturates at DW.
- Slot shorter than DW: remaining bits dropped; next channel starts MSB-aligned at its boundary.
- Right boundary seen while IDLE: ignored.

FIFO:
- Push when s_valid & s_ready. s_ready depends on current level only: no push at level==FIFO_DEPTH even with a same-cycle pop.
- Level update: push only +1; pop only -1; push and pop together, unchanged.
- Order strictly FIFO; pointers wrap modulo FIFO_DEPTH.

Enable and clear:
- en=0 (sampled each clk): next edge sdo=0, state IDLE, no pops. Pushes still accepted.
- Re-enabling resumes at the next left boundary.
- underflow: set has priority over clr_udf in the same cycle.

Test Plan:
1. Defaults, master 32-bit slots. Push L=0xA0B0C1, R=0x5D0F03. Rising-edge receiver with one-bit delay captures L=0xA0B0C1 and R=0x5D0F03, 8 pad zeros per slot. level 1->0 at left start.
2. No push, en=1, run 2 frames -> sdo constantly 0, underflow=1. Pulse clr_udf -> underflow=0.
3. mono=1, push L=0x123456, R=0xFFFFFF -> both slots carry 0x123456.
4. Push 5 frames back-to-back with no frames running -> level=4, s_ready=0, 5th held. Run frames -> 5 frames received in push order; s_ready returns to 1 after first pop.
5. Master 16-bit slots, L=0xA0B0C1, R=0x5D0F03 -> receiver gets 0xA0B0, 0x5D0F. Next frame is MSB-aligned with no residue.
6. Deassert en mid-left-slot -> sdo=0 within 1 clk, no pop. Reassert mid-frame -> next data at the following left start.
7. Assert rst_n=0 mid-frame -> level=0, sdo=0 on that edge.
